// File: rtl/rll27_decoder.sv
// Serial RLL(2,7) decoder: parses 4/6/8-bit codewords into 2/3/4-bit groups, 1 clock after the last code bit.
// No backpressure; en_i paces the input and a pulse is issued per decoded group or error.
// RLL_CONSTRAINT_CHECK_EN adds a run-length monitor on the raw code stream (rll_viol_o).
module rll27_decoder #(
  parameter int CNT_W      = 16,
  parameter bit ERR_RESYNC = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             code_i,
  input  logic             sync_i,
  output logic [3:0]       data_o,
  output logic [2:0]       len_o,
  output logic             valid_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] grp_cnt_o,
  output logic             rll_viol_o
);

  typedef enum logic [1:0] {IDLE, ACC, ERROR} state_t;

  state_t     state, state_nxt;
  logic [6:0] acc, acc_nxt;
  logic [7:0] shifted;
  logic [3:0] cnt, cnt_nxt, cnt_inc;
  logic       hit;
  logic [3:0] hit_data;
  logic [2:0] hit_len;
  logic       valid_nxt, err_nxt;

  // IDLE holds acc=0/cnt=0, so the first bit of a word takes the same shift path as ACC.
  always_comb begin
    shifted  = {acc, code_i};
    cnt_inc  = cnt + 4'd1;
    hit      = 1'b0;
    hit_data = 4'd0;
    hit_len  = 3'd0;
    case (cnt_inc)
      4'd4: case (shifted[3:0])
        4'b0100: begin hit = 1'b1; hit_data = 4'b0010; hit_len = 3'd2; end
        4'b1000: begin hit = 1'b1; hit_data = 4'b0011; hit_len = 3'd2; end
        default: ;
      endcase
      4'd6: case (shifted[5:0])
        6'b000100: begin hit = 1'b1; hit_data = 4'b0000; hit_len = 3'd3; end
        6'b100100: begin hit = 1'b1; hit_data = 4'b0010; hit_len = 3'd3; end
        6'b001000: begin hit = 1'b1; hit_data = 4'b0011; hit_len = 3'd3; end
        default: ;
      endcase
      4'd8: case (shifted)
        8'b00100100: begin hit = 1'b1; hit_data = 4'b0010; hit_len = 3'd4; end
        8'b00001000: begin hit = 1'b1; hit_data = 4'b0011; hit_len = 3'd4; end
        default: ;
      endcase
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (en_i) begin
      if (sync_i) begin
        // sync wins over everything: any partial word is dropped silently
        acc_nxt   = {6'd0, code_i};
        cnt_nxt   = 4'd1;
        state_nxt = ACC;
      end else if (state != ERROR) begin
        if (hit) begin
          valid_nxt = 1'b1;
          acc_nxt   = 7'd0;
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else if (cnt_inc == 4'd8) begin
          err_nxt   = 1'b1;
          acc_nxt   = 7'd0;
          cnt_nxt   = 4'd0;
          state_nxt = ERR_RESYNC ? IDLE : ERROR;
        end else begin
          acc_nxt   = shifted[6:0];
          cnt_nxt   = cnt_inc;
          state_nxt = ACC;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      acc       <= 7'd0;
      cnt       <= 4'd0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      data_o    <= 4'd0;
      len_o     <= 3'd0;
      grp_cnt_o <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      valid_o <= valid_nxt;
      err_o   <= err_nxt;
      if (valid_nxt) begin
        data_o <= hit_data;
        len_o  <= hit_len;
        if (grp_cnt_o != {CNT_W{1'b1}})
          grp_cnt_o <= grp_cnt_o + 1'b1;
      end
    end
  end

  assign busy_o = (cnt != 4'd0);

`ifdef RLL_CONSTRAINT_CHECK_EN
  logic [3:0] zrun;
  logic       seen_one;

  // Zero-run monitor spans codeword boundaries and ignores sync; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      zrun       <= 4'd0;
      seen_one   <= 1'b0;
      rll_viol_o <= 1'b0;
    end else begin
      rll_viol_o <= 1'b0;
      if (en_i) begin
        if (code_i) begin
          rll_viol_o <= seen_one && (zrun < 4'd2);
          zrun       <= 4'd0;
          seen_one   <= 1'b1;
        end else begin
          if (zrun != 4'd8)
            zrun <= zrun + 4'd1;
          rll_viol_o <= (zrun == 4'd7);
        end
      end
    end
  end
`else
  assign rll_viol_o = 1'b0;
`endif

endmodule

// File: tb/tb_rll27_decoder.sv
// Drives two decoders (ERR_RESYNC=1 with a narrow counter, ERR_RESYNC=0) from one stream and
// compares every output each cycle against a codeword-table reference model.
module tb_rll27_decoder;

  logic clk = 1'b0;
  logic rst_i, en_i, code_i, sync_i;

  logic [3:0]  data1, data0;
  logic [2:0]  len1, len0;
  logic        valid1, valid0, err1, err0, busy1, busy0, viol1, viol0;
  logic [3:0]  grp1;
  logic [15:0] grp0;

  int vectors = 0;
  int miscompares = 0;

`ifdef RLL_CONSTRAINT_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  always #5 clk = ~clk;

  rll27_decoder #(.CNT_W(4), .ERR_RESYNC(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .code_i(code_i), .sync_i(sync_i),
    .data_o(data1), .len_o(len1), .valid_o(valid1), .err_o(err1), .busy_o(busy1),
    .grp_cnt_o(grp1), .rll_viol_o(viol1));

  rll27_decoder #(.CNT_W(16), .ERR_RESYNC(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .code_i(code_i), .sync_i(sync_i),
    .data_o(data0), .len_o(len0), .valid_o(valid0), .err_o(err0), .busy_o(busy0),
    .grp_cnt_o(grp0), .rll_viol_o(viol0));

  // codeword table: code length, code value, data value, data length
  int tbl_clen [7] = '{4, 4, 6, 6, 6, 8, 8};
  int tbl_code [7] = '{8'b0100, 8'b1000, 8'b000100, 8'b100100, 8'b001000, 8'b00100100, 8'b00001000};
  int tbl_data [7] = '{2, 3, 0, 2, 3, 2, 3};
  int tbl_dlen [7] = '{2, 2, 3, 3, 3, 4, 4};

  // reference model state, index = ERR_RESYNC value of the instance
  int m_val [2], m_n [2], grp_max [2];
  bit m_hold [2];
  int e_valid [2], e_err [2], e_data [2], e_len [2], e_grp [2], e_busy [2];
  int zeros;
  bit seen_one;
  int e_viol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_val[m] = 0; m_n[m] = 0; m_hold[m] = 1'b0;
      e_valid[m] = 0; e_err[m] = 0; e_data[m] = 0; e_len[m] = 0; e_grp[m] = 0; e_busy[m] = 0;
    end
    zeros = 0; seen_one = 1'b0; e_viol = 0;
  endtask

  task automatic model_step(input bit en, input bit code, input bit sync);
    for (int m = 0; m < 2; m++) begin
      e_valid[m] = 0;
      e_err[m]   = 0;
      if (en) begin
        if (sync) begin
          m_val[m] = int'(code); m_n[m] = 1; m_hold[m] = 1'b0;
        end else if (!m_hold[m]) begin
          bit found = 1'b0;
          m_val[m] = m_val[m] * 2 + int'(code);
          m_n[m]++;
          for (int k = 0; k < 7; k++)
            if (tbl_clen[k] == m_n[m] && tbl_code[k] == m_val[m]) begin
              found = 1'b1;
              e_data[m] = tbl_data[k];
              e_len[m]  = tbl_dlen[k];
            end
          if (found) begin
            e_valid[m] = 1;
            if (e_grp[m] < grp_max[m]) e_grp[m]++;
            m_n[m] = 0; m_val[m] = 0;
          end else if (m_n[m] == 8) begin
            e_err[m] = 1;
            m_n[m] = 0; m_val[m] = 0;
            m_hold[m] = (m == 0);
          end
        end
      end
      e_busy[m] = (m_n[m] != 0);
    end
    e_viol = 0;
    if (en) begin
      if (code) begin
        e_viol = (seen_one && zeros < 2) ? 1 : 0;
        zeros = 0;
        seen_one = 1'b1;
      end else begin
        zeros++;
        e_viol = (zeros == 8) ? 1 : 0;
      end
    end
    if (!FEAT) e_viol = 0;
  endtask

  task automatic check_all();
    chk("valid1", valid1, e_valid[1]); chk("err1", err1, e_err[1]);
    chk("data1", data1, e_data[1]);    chk("len1", len1, e_len[1]);
    chk("grp1", grp1, e_grp[1]);       chk("busy1", busy1, e_busy[1]);
    chk("viol1", viol1, e_viol);
    chk("valid0", valid0, e_valid[0]); chk("err0", err0, e_err[0]);
    chk("data0", data0, e_data[0]);    chk("len0", len0, e_len[0]);
    chk("grp0", grp0, e_grp[0]);       chk("busy0", busy0, e_busy[0]);
    chk("viol0", viol0, e_viol);
  endtask

  // inputs change on negedge, DUT samples on posedge, outputs checked on the next negedge
  task automatic apply(input bit en, input bit code, input bit sync);
    en_i = en; code_i = code; sync_i = sync;
    @(posedge clk);
    model_step(en, code, sync);
    @(negedge clk);
    check_all();
    en_i = 1'b0; sync_i = 1'b0;
  endtask

  task automatic feed(input logic [7:0] bits, input int n, input bit gap, input bit sync_first);
    for (int i = n - 1; i >= 0; i--) begin
      apply(1'b1, bits[i], sync_first && (i == n - 1));
      if (gap) apply(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; en_i = 1'b0; code_i = 1'b0; sync_i = 1'b0;
    grp_max[1] = 15; grp_max[0] = 65535;
    @(negedge clk);
    do_reset();

    feed(8'b0100, 4, 0, 0); feed(8'b1000, 4, 0, 0); feed(8'b000100, 6, 0, 0);
    chk("basic_grp", grp1, 3);
    feed(8'b100100, 6, 0, 0); feed(8'b001000, 6, 0, 0);
    feed(8'b00100100, 8, 0, 0); feed(8'b00001000, 8, 0, 0);

    do_reset();
    feed(8'b0100, 4, 1, 0); feed(8'b1000, 4, 1, 0); feed(8'b000100, 6, 1, 0);
    chk("gap_grp", grp0, 3);

    feed(8'b11111111, 8, 0, 0);
    feed(8'b0100, 4, 0, 0);
    feed(8'b0100, 4, 0, 1);

    feed(8'b00, 2, 0, 0);
    do_reset();
    feed(8'b1000, 4, 0, 0);
    chk("post_rst_data", data1, 3);
    chk("post_rst_len", len0, 2);

    feed(8'b00, 2, 0, 0);
    feed(8'b1000, 4, 0, 1);
    chk("sync_drop_grp", grp0, 2);

    feed(8'b0100, 4, 0, 0); feed(8'b1000, 4, 0, 0);
    feed(8'b0101, 4, 0, 0); feed(8'b0000, 4, 0, 0);
    feed(8'b0100, 4, 0, 1);

    for (int w = 0; w < 300; w++) begin
      bit gap  = ($urandom_range(0, 2) == 0);
      bit sync = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        feed(8'($urandom), $urandom_range(1, 8), gap, sync);
      end else begin
        int k = $urandom_range(0, 6);
        feed(8'(tbl_code[k]), tbl_clen[k], gap, sync);
      end
    end
    chk("grp_saturated", grp1, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
